// File: rtl/windowed_accumulator.sv
// Windowed accumulator: ADD/SUB/LOAD/CLEAR on a registered accumulator, with a pulse every WINDOW operations.
// Define WINDOWED_ACCUMULATOR_SATURATE_EN to clamp on overflow/underflow instead of wrapping.
module windowed_accumulator #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 8,
    localparam int CNT_W = ($clog2(WINDOW) < 1) ? 1 : $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(WINDOW - 1);

    logic             window_start;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] result;
    logic             op_overflow;
    logic             last_op;

    // The accumulator restarts from zero once the previous window has been reported.
    assign base     = window_start ? '0 : out;
    assign sum_ext  = {1'b0, base} + {1'b0, in};
    assign diff_ext = {1'b0, base} - {1'b0, in};
    assign last_op  = (count == COUNT_LAST);

    always_comb begin
        result      = in;
        op_overflow = 1'b0;
        case (op)
            OP_ADD: begin
                op_overflow = sum_ext[WIDTH];
`ifdef WINDOWED_ACCUMULATOR_SATURATE_EN
                result = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
                result = sum_ext[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                op_overflow = diff_ext[WIDTH];
`ifdef WINDOWED_ACCUMULATOR_SATURATE_EN
                result = diff_ext[WIDTH] ? '0 : diff_ext[WIDTH-1:0];
`else
                result = diff_ext[WIDTH-1:0];
`endif
            end
            default: begin
                result      = in;
                op_overflow = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out          <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            overflow     <= 1'b0;
            window_start <= 1'b1;
        end else if (in_valid) begin
            if (op == OP_CLEAR) begin
                out          <= '0;
                count        <= '0;
                out_valid    <= 1'b0;
                overflow     <= 1'b0;
                window_start <= 1'b1;
            end else begin
                out <= result;
                // The first operation of a window drops any overflow left from the last one.
                overflow <= (window_start ? 1'b0 : overflow) | op_overflow;
                if (last_op) begin
                    count        <= '0;
                    out_valid    <= 1'b1;
                    window_start <= 1'b1;
                end else begin
                    count        <= count + CNT_W'(1);
                    out_valid    <= 1'b0;
                    window_start <= 1'b0;
                end
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/windowed_accumulator.md
WINDOWED_ACCUMULATOR -- requirements
Module: windowed_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data and accumulator width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter WINDOW, default 8, number of accepted operations per accumulation window (legal range 1..65535).
REQ-003 The block SHALL derive local CNT_W = max(1, clog2(WINDOW)).
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-006 The block SHALL have port in, input, WIDTH, unsigned operand.
REQ-007 The block SHALL have port in_valid, input, 1, operation accept strobe.
REQ-008 The block SHALL have port op, input, 2, operation code: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
REQ-009 The block SHALL have port out, output, WIDTH, registered accumulator value.
REQ-010 The block SHALL have port out_valid, output, 1, one-cycle window-complete pulse.
REQ-011 The block SHALL have port count, output, CNT_W, operations accepted in current window.
REQ-012 The block SHALL have port overflow, output, 1, per-window sticky arithmetic overflow/underflow flag.

Function
REQ-013 An operation SHALL be accepted on a rising clk edge where reset=0 and in_valid=1; all outputs update at that edge (one-cycle latency, no combinational path from in to out).
REQ-014 With in_valid=0 and reset=0, out, count and overflow SHALL hold and out_valid SHALL be 0.
REQ-015 Base value SHALL be out, except 0 when the previous accepted operation completed a window (start-of-window flag set).
REQ-016 ADD SHALL produce base+in, SUB base-in, LOAD in, all unsigned WIDTH-bit.
REQ-017 ADD carry-out or SUB borrow SHALL set overflow; overflow SHALL stay set until window start, CLEAR or reset.
REQ-018 ADD, SUB and LOAD SHALL increment count; when count=WINDOW-1 at acceptance, count SHALL wrap to 0, out_valid SHALL pulse 1 for exactly that cycle, and the start-of-window flag SHALL be set.
REQ-019 The first accepted ADD/SUB/LOAD of a new window SHALL clear overflow before applying its own overflow result.
REQ-020 CLEAR SHALL set out=0, count=0, overflow=0, out_valid=0, set the start-of-window flag, and SHALL NOT count as a window operation.
REQ-021 With WINDOW=1, every accepted ADD/SUB/LOAD SHALL pulse out_valid, and out SHALL equal the single-operation result from base 0.
REQ-022 out SHALL keep the completed window sum after out_valid until the next accepted operation.

Reset
REQ-023 reset=1 at a rising edge SHALL set out=0, count=0, out_valid=0, overflow=0, start-of-window flag=1, overriding any in_valid/op in that cycle.
REQ-024 Reset asserted mid-window SHALL discard the partial window; no out_valid pulse for it.

Configuration
REQ-025 Macro WINDOWED_ACCUMULATOR_SATURATE_EN SHALL select overflow handling.
REQ-026 With the macro defined, ADD overflow SHALL clamp out to all-ones and SUB underflow SHALL clamp out to 0.
REQ-027 Without the macro, results SHALL wrap modulo 2^WIDTH.
REQ-028 The overflow flag SHALL be set identically in both builds.

Verification (WIDTH=16, WINDOW=4 unless stated)
REQ-029 Reset, then ADD 5 four times -> out 5,10,15,20; count 1,2,3,0; out_valid=1 only with out=20; then ADD 7 -> out=7, overflow=0.
REQ-030 LOAD 65530, then ADD 10 -> out=4, overflow=1 without macro; out=65535, overflow=1 with macro; overflow persists through in_valid=0 cycles.
REQ-031 LOAD 3, then SUB 5 -> out=65534 without macro, out=0 with macro; overflow=1.
REQ-032 ADD 5, ADD 5, reset for one cycle, then ADD 200 four times -> out=0 after reset, then 200,400,600,800, single out_valid with out=800.
REQ-033 ADD 9, ADD 9, CLEAR, ADD 1 four times -> out=0, count=0 after CLEAR; out_valid with out=4 on fourth ADD.
REQ-034 WINDOW=1: ADD 5, ADD 6 with in_valid gap -> out=5 then 6, out_valid on each accepting edge only.
